// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard unit: register
// addresses and control flowing in, forwarding selects, stalls and flushes out.
interface hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              MemReadE, RegWriteM, RegWriteW, PCSrcE, MduStartE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              MduBusy;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output MemReadE, RegWriteM, RegWriteW, PCSrcE, MduStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MduBusy, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  MemReadE, RegWriteM, RegWriteW, PCSrcE, MduStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MduBusy, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and a
// multicycle-unit occupancy FSM, with a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int                CW        = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam bit                MDU_MULTI = (MDU_LAT > 1);
  localparam logic [CW-1:0]     CNT_LOAD  = MDU_MULTI ? CW'(MDU_LAT - 2) : '0;
  localparam logic [ADDR_W-1:0] REG_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CW-1:0]    mduCount;
  logic [CNT_W-1:0] stallCount;
  logic             loadUse, mduStart;
  logic             stallF, stallD, stallE, flushD, flushE, flushM, mduBusy;
  logic [1:0]       forwardA, forwardB;

  // The M stage holds the younger result, so it beats W when both match.
  always_comb begin
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (hz.RegWriteM && (hz.RdM != REG_ZERO) && (hz.RdM == hz.Rs1E))
      forwardA = 2'b10;
    else if (hz.RegWriteW && (hz.RdW != REG_ZERO) && (hz.RdW == hz.Rs1E))
      forwardA = 2'b01;
    if (hz.RegWriteM && (hz.RdM != REG_ZERO) && (hz.RdM == hz.Rs2E))
      forwardB = 2'b10;
    else if (hz.RegWriteW && (hz.RdW != REG_ZERO) && (hz.RdW == hz.Rs2E))
      forwardB = 2'b01;
  end

  assign loadUse  = hz.MemReadE && (hz.RdE != REG_ZERO) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mduStart = (state == IDLE) && hz.MduStartE && MDU_MULTI;

  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    mduBusy = 1'b0;
    if (!rst) begin
      if (state == BUSY) begin
        stallF  = 1'b1;
        stallD  = 1'b1;
        stallE  = 1'b1;
        flushM  = 1'b1;
        mduBusy = 1'b1;
      end else if (mduStart) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (hz.PCSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loadUse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // BUSY ends once the decremented count would reach zero, so it lasts
  // MDU_LAT-2 cycles and the start cycle brings the op to MDU_LAT-1 stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mduCount   <= '0;
      stallCount <= '0;
    end else begin
      if (stallF && (stallCount != CNT_MAX))
        stallCount <= stallCount + CNT_W'(1);
      case (state)
        IDLE: begin
          if (mduStart) begin
            state    <= BUSY;
            mduCount <= CNT_LOAD;
          end
        end
        BUSY: begin
          if ((mduCount == '0) || (mduCount == CW'(1))) begin
            state    <= IDLE;
            mduCount <= '0;
          end else begin
            mduCount <= mduCount - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hz.ForwardAE  = forwardA;
  assign hz.ForwardBE  = forwardB;
  assign hz.StallF     = stallF;
  assign hz.StallD     = stallD;
  assign hz.StallE     = stallE;
  assign hz.FlushD     = flushD;
  assign hz.FlushE     = flushE;
  assign hz.FlushM     = flushM;
  assign hz.MduBusy    = mduBusy;
  assign hz.StallCount = stallCount;

endmodule
